// File: rtl/vga_fb_arbiter.sv
// Frame-buffer SRAM arbiter: display reads take absolute priority, and scanner writes
// are buffered in a small FIFO that drains into the SRAM only while the display is idle.
module vga_fb_arbiter #(
    parameter int DATA_W       = 24,
    parameter int ADDR_W       = 19,
    parameter int FRAME_PIXELS = 307200,
    parameter int WBUF_DEPTH   = 4
) (
    input  logic                          iCLK25,
    input  logic                          iRST_N,
    input  logic                          iDisp_Req,
    input  logic                          iDisp_FrameStart,
    output logic [DATA_W-1:0]             oDisp_Data,
    output logic                          oDisp_Valid,
    input  logic                          iScan_Valid,
    input  logic [ADDR_W-1:0]             iScan_Addr,
    input  logic [DATA_W-1:0]             iScan_Data,
    output logic                          oScan_Ready,
    output logic [ADDR_W-1:0]             oMem_Addr,
    output logic [DATA_W-1:0]             oMem_WData,
    output logic                          oMem_WE,
    output logic                          oMem_RE,
    input  logic [DATA_W-1:0]             iMem_RData,
    output logic [$clog2(WBUF_DEPTH):0]   oWbuf_Level
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(WBUF_DEPTH);

    // Encoding chosen so that RE and WE come straight off state flops and cannot both be set.
    typedef enum logic [1:0] {
        GNT_IDLE  = 2'b00,
        GNT_READ  = 2'b01,
        GNT_WRITE = 2'b10
    } grant_t;

    grant_t grant, grant_next;

    logic [ADDR_W-1:0] wbuf_addr [WBUF_DEPTH];
    logic [DATA_W-1:0] wbuf_data [WBUF_DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [LVL_W-1:0]  level;
    logic [ADDR_W-1:0] disp_addr, rd_addr;
    logic              push, pop, rd_pend;

    assign oScan_Ready = (level < DEPTH_LVL);
    assign oWbuf_Level = level;
    assign push        = iScan_Valid & oScan_Ready;
    assign pop         = (grant_next == GNT_WRITE);
    assign rd_addr     = iDisp_FrameStart ? '0 : disp_addr;
    assign oMem_RE     = grant[0];
    assign oMem_WE     = grant[1];

    // NOTE: the default is assigned before any branch, so no path can leave grant_next unassigned (no latch).
    always_comb begin
        grant_next = GNT_IDLE;
        if (iDisp_Req)
            grant_next = GNT_READ;
        else if (level != '0)
            grant_next = GNT_WRITE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iCLK25 or negedge iRST_N) begin
        if (!iRST_N)
            grant <= GNT_IDLE;
        else
            grant <= grant_next;
    end

    always_ff @(posedge iCLK25 or negedge iRST_N) begin
        if (!iRST_N) begin
            oMem_Addr   <= '0;
            oMem_WData  <= '0;
            disp_addr   <= '0;
            rd_pend     <= 1'b0;
            oDisp_Valid <= 1'b0;
            oDisp_Data  <= '0;
            head        <= '0;
            tail        <= '0;
            level       <= '0;
        end else begin
            case (grant_next)
                GNT_READ: begin
                    oMem_Addr <= rd_addr;
                    disp_addr <= (rd_addr == LAST_PIX) ? '0 : rd_addr + ADDR_W'(1);
                end
                GNT_WRITE: begin
                    oMem_Addr  <= wbuf_addr[head];
                    oMem_WData <= wbuf_data[head];
                    if (iDisp_FrameStart)
                        disp_addr <= '0;
                end
                default: begin
                    if (iDisp_FrameStart)
                        disp_addr <= '0;
                end
            endcase

            // The SRAM returns data one cycle after RE; register it once more for the display.
            rd_pend     <= oMem_RE;
            oDisp_Valid <= rd_pend;
            if (rd_pend)
                oDisp_Data <= iMem_RData;

            if (push)
                tail <= tail + PTR_W'(1);
            if (pop)
                head <= head + PTR_W'(1);
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // NOTE: the buffer storage has no reset; the level and pointers alone decide which entries are live.
    always_ff @(posedge iCLK25) begin
        if (push) begin
            wbuf_addr[tail] <= iScan_Addr;
            wbuf_data[tail] <= iScan_Data;
        end
    end

endmodule
